adc_spi_cfg_seq: RTL and testbench

//  Autonomous SPI configuration sequencer for AD9643-class ADCs. On start it walks an external

---
 rtl/adc_spi_cfg_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_adc_spi_cfg_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_cfg_seq.sv
// adc_spi_cfg_seq
//   Autonomous SPI configuration sequencer for AD9643-class ADCs. On start it
//   waits a power-up delay, then walks an external register LUT and sends each
//   {addr16,data8} entry as one 24-bit SPI write frame (mode 0, MSB first).
//   An entry with reg_addr 16'hFFFF ends the table early.
//
//   Optional feature macro: ADC_CFG_VERIFY_EN
//     When defined, every write except to address 0x0FF is followed by a read
//     frame of the same address. A readback that differs from the written data
//     raises err and latches the first failing LUT index in err_index.
//
// Parameters
//   LUT_DEPTH    number of LUT entries scanned (1..1023)
//   CLK_DIV      clk cycles per SCLK half-period (>=1)
//   CS_GAP       clk cycles CSB stays high between frames (>=1)
//   STARTUP_CYC  clk cycles waited after start before the first frame
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle pulse, begins a sequence when idle
//   lut_index       LUT address to the external table
//   lut_data        {reg_addr[15:0], reg_data[7:0]} for lut_index
//   spi_csb         chip select, active low
//   spi_sclk        SPI clock, idle low
//   spi_sdio_o/_oe  serial data out and its output enable
//   spi_sdio_i      serial data in (readback only)
//   busy            sequence in progress
//   done            one-cycle pulse at sequence end
//   cfg_ok          last sequence finished without error
//   err, err_index  readback mismatch flag and first failing index
module adc_spi_cfg_seq #(
    parameter int unsigned LUT_DEPTH   = 12,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CS_GAP      = 8,
    parameter int unsigned STARTUP_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_sdio_o,
    output logic        spi_sdio_oe,
    input  logic        spi_sdio_i,
    output logic        busy,
    output logic        done,
    output logic        cfg_ok,
    output logic        err,
    output logic [9:0]  err_index
);

    localparam int unsigned IDX_W   = 10;
    localparam int unsigned FRAME_W = 24;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BIT_W   = 5;

    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(LUT_DEPTH - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST     = CNT_W'(STARTUP_CYC);
    localparam logic [CNT_W-1:0] DIV_LAST      = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST      = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] RD_TURN_BIT   = BIT_W'(15);
    localparam logic [12:0]      SELF_CLR_ADDR = 13'h0FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_FIN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;        // startup, SCLK half-period and gap timer
    logic [BIT_W-1:0]   bit_cnt;    // falling SCLK edges completed in this frame
    logic [FRAME_W-1:0] shreg;
    logic [12:0]        cur_addr;   // address of the entry being written
    logic               rd_phase;   // current frame is the readback of cur_addr

    logic [FRAME_W-1:0] frame_c;
    logic               is_end_c;
    logic               want_read_c;

`ifdef ADC_CFG_VERIFY_EN
    logic [7:0] cur_data;
    logic [7:0] rd_data;

    // Readback follows each write, except the self-clearing transfer register.
    assign want_read_c = !rd_phase && (cur_addr != SELF_CLR_ADDR);
`else
    logic unused_sdio_i;

    assign unused_sdio_i = spi_sdio_i;
    assign want_read_c   = 1'b0;
`endif

    // reg_addr[15:13] is dropped; W1:W0 = 00 selects a single-byte transfer.
    assign is_end_c = (lut_data[23:8] == 16'hFFFF);
    assign frame_c  = rd_phase ? {1'b1, 2'b00, cur_addr, 8'h00}
                               : {1'b0, 2'b00, lut_data[20:0]};

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            cur_addr    <= '0;
            rd_phase    <= 1'b0;
            lut_index   <= '0;
            spi_csb     <= 1'b1;
            spi_sclk    <= 1'b0;
            spi_sdio_o  <= 1'b0;
            spi_sdio_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_ok      <= 1'b0;
            err         <= 1'b0;
            err_index   <= '0;
`ifdef ADC_CFG_VERIFY_EN
            cur_data    <= '0;
            rd_data     <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        cfg_ok    <= 1'b0;
                        err       <= 1'b0;
                        err_index <= '0;
                        lut_index <= '0;
                        rd_phase  <= 1'b0;
                        cnt       <= '0;
                        state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_LOAD: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!rd_phase && is_end_c) begin
                        state <= S_FIN;
                    end else begin
                        shreg       <= frame_c;
                        spi_csb     <= 1'b0;
                        spi_sdio_oe <= 1'b1;
                        spi_sdio_o  <= frame_c[FRAME_W-1];
                        state       <= S_SHIFT;
                        if (!rd_phase) begin
                            cur_addr <= lut_data[20:8];
`ifdef ADC_CFG_VERIFY_EN
                            cur_data <= lut_data[7:0];
`endif
                        end
                    end
                end

                S_SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        spi_sclk <= ~spi_sclk;
                        if (!spi_sclk) begin
                            // Rising edge: slave samples; readback data captured here.
`ifdef ADC_CFG_VERIFY_EN
                            if (rd_phase && (bit_cnt > RD_TURN_BIT)) begin
                                rd_data <= {rd_data[6:0], spi_sdio_i};
                            end
`endif
                        end else if (bit_cnt == LAST_BIT) begin
                            // Last falling edge closes the frame.
                            spi_csb     <= 1'b1;
                            spi_sdio_oe <= 1'b0;
                            spi_sdio_o  <= 1'b0;
                            bit_cnt     <= '0;
                            state       <= S_GAP;
`ifdef ADC_CFG_VERIFY_EN
                            if (rd_phase && (rd_data != cur_data) && !err) begin
                                err       <= 1'b1;
                                err_index <= lut_index;
                            end
`endif
                        end else begin
                            bit_cnt    <= bit_cnt + BIT_W'(1);
                            shreg      <= {shreg[FRAME_W-2:0], 1'b0};
                            spi_sdio_o <= shreg[FRAME_W-2];
                            // Read frame: release SDIO after the 16 instruction bits.
                            if (rd_phase && (bit_cnt == RD_TURN_BIT)) begin
                                spi_sdio_oe <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (want_read_c) begin
                            rd_phase <= 1'b1;
                            state    <= S_LOAD;
                        end else begin
                            rd_phase <= 1'b0;
                            if (lut_index == LAST_IDX) begin
                                state <= S_FIN;
                            end else begin
                                lut_index <= lut_index + IDX_W'(1);
                                state     <= S_LOAD;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_FIN: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    cfg_ok <= ~err;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_cfg_seq.sv
// tb_adc_spi_cfg_seq
//   Directed bench for adc_spi_cfg_seq. Instance a: 2-entry LUT, no startup
//   wait. Instance b: 12-entry LUT, 1000-cycle startup wait. Each instance has
//   a frame monitor on its SPI pins and an SDIO slave that echoes written data.
module tb_adc_spi_cfg_seq;

`ifdef ADC_CFG_VERIFY_EN
    localparam int VERIFY = 1;
`else
    localparam int VERIFY = 0;
`endif
    localparam logic [12:0] BAD_ADDR = 13'h0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance a ----------------
    logic        a_start = 1'b0;
    logic [9:0]  a_idx;
    logic [23:0] a_data;
    logic        a_csb, a_sclk, a_sdo, a_oe, a_busy, a_done, a_ok, a_err;
    logic [9:0]  a_eidx;
    logic        a_sdi = 1'b0;
    logic [23:0] lut_a [0:1];

    assign a_data = lut_a[a_idx[0]];

    adc_spi_cfg_seq #(.LUT_DEPTH(2), .CLK_DIV(2), .CS_GAP(8), .STARTUP_CYC(0)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .lut_index(a_idx), .lut_data(a_data),
        .spi_csb(a_csb), .spi_sclk(a_sclk), .spi_sdio_o(a_sdo), .spi_sdio_oe(a_oe),
        .spi_sdio_i(a_sdi), .busy(a_busy), .done(a_done), .cfg_ok(a_ok), .err(a_err),
        .err_index(a_eidx)
    );

    logic        a_sclk_q = 1'b0, a_csb_q = 1'b1;
    logic [23:0] a_sh = '0;
    logic [7:0]  a_echo = '0, a_rd = '0;
    int          a_bits = 0, a_low = 0, a_falls = 0, a_dones = 0;
    logic [23:0] a_frames [$];
    int          a_lens [$];
    int          a_nbits [$];

    always @(negedge clk) begin
        if (!a_csb) a_low++;
        if (a_sclk && !a_sclk_q && !a_csb) begin
            a_sh = {a_sh[22:0], a_sdo};
            a_bits++;
        end
        if (!a_sclk && a_sclk_q && !a_csb) begin
            a_falls++;
            if (a_falls == 16) a_rd = a_echo;
            if (a_falls >= 16) begin
                a_sdi = a_rd[7];
                a_rd  = {a_rd[6:0], 1'b0};
            end
        end
        if (a_csb && !a_csb_q) begin
            a_frames.push_back(a_sh);
            a_lens.push_back(a_low);
            a_nbits.push_back(a_bits);
            if (!a_sh[23]) a_echo = a_sh[7:0];
        end
        if (a_csb) begin
            a_low = 0; a_bits = 0; a_falls = 0;
        end
        if (a_done) a_dones++;
        a_sclk_q = a_sclk;
        a_csb_q  = a_csb;
    end

    // ---------------- instance b ----------------
    logic        b_start = 1'b0;
    logic [9:0]  b_idx;
    logic [23:0] b_data;
    logic        b_csb, b_sclk, b_sdo, b_oe, b_busy, b_done, b_ok, b_err;
    logic [9:0]  b_eidx;
    logic        b_sdi = 1'b0;
    logic [23:0] lut_b [0:11];
    logic [7:0]  slave_mem [0:8191];

    assign b_data = (b_idx < 10'd12) ? lut_b[b_idx[3:0]] : 24'hFFFFFF;

    adc_spi_cfg_seq #(.LUT_DEPTH(12), .CLK_DIV(2), .CS_GAP(8), .STARTUP_CYC(1000)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .lut_index(b_idx), .lut_data(b_data),
        .spi_csb(b_csb), .spi_sclk(b_sclk), .spi_sdio_o(b_sdo), .spi_sdio_oe(b_oe),
        .spi_sdio_i(b_sdi), .busy(b_busy), .done(b_done), .cfg_ok(b_ok), .err(b_err),
        .err_index(b_eidx)
    );

    logic        b_sclk_q = 1'b0, b_csb_q = 1'b1;
    logic [23:0] b_sh = '0;
    logic [7:0]  b_rd = '0;
    int          b_bits = 0, b_low = 0, b_falls = 0, b_dones = 0, b_pre_edges = 0;
    logic [23:0] b_frames [$];
    int          b_lens [$];

    always @(negedge clk) begin
        if (!b_csb) b_low++;
        if (b_sclk && !b_sclk_q && b_csb) b_pre_edges++;
        if (b_sclk && !b_sclk_q && !b_csb) begin
            b_sh = {b_sh[22:0], b_sdo};
            b_bits++;
        end
        if (!b_sclk && b_sclk_q && !b_csb) begin
            b_falls++;
            if (b_falls == 16) b_rd = slave_mem[b_sh[12:0]];
            if (b_falls >= 16) begin
                b_sdi = b_rd[7];
                b_rd  = {b_rd[6:0], 1'b0};
            end
        end
        if (b_csb && !b_csb_q) begin
            b_frames.push_back(b_sh);
            b_lens.push_back(b_low);
            // Faulty slave register: always reads back 0x00.
            if (!b_sh[23] && b_bits == 24)
                slave_mem[b_sh[20:8]] = (b_sh[20:8] == BAD_ADDR) ? 8'h00 : b_sh[7:0];
        end
        if (b_csb) begin
            b_low = 0; b_bits = 0; b_falls = 0;
        end
        if (b_done) b_dones++;
        b_sclk_q = b_sclk;
        b_csb_q  = b_csb;
    end

    // ---------------- helpers ----------------
    task automatic clear_mon();
        a_frames.delete(); a_lens.delete(); a_nbits.delete(); a_dones = 0;
        b_frames.delete(); b_lens.delete(); b_dones = 0; b_pre_edges = 0;
    endtask

    task automatic pulse_start(input bit sel_b);
        @(negedge clk);
        if (sel_b) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        a_start = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b, input int budget, input string tag);
        int n = 0;
        while ((sel_b ? b_busy : a_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_timeout"}, 32'(sel_b ? b_busy : a_busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Expected frames of one full run on instance a.
    task automatic check_a_run(input string tag);
        logic [23:0] exp [$];
        exp.push_back(24'h000503);
        if (VERIFY != 0) exp.push_back(24'h800500);
        exp.push_back(24'h00FF01);
        check({tag, "_nframes"}, 32'(a_frames.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < a_frames.size(); i++) begin
            check($sformatf("%s_frame%0d", tag, i), 32'(a_frames[i]), 32'(exp[i]));
            check($sformatf("%s_csb_low%0d", tag, i), 32'(a_lens[i]), 32'd96);
            check($sformatf("%s_bits%0d", tag, i), 32'(a_nbits[i]), 32'd24);
        end
        check({tag, "_dones"}, 32'(a_dones), 32'd1);
        check({tag, "_cfg_ok"}, 32'(a_ok), 32'd1);
        check({tag, "_err"}, 32'(a_err), 32'd0);
        check({tag, "_err_index"}, 32'(a_eidx), 32'd0);
        check({tag, "_lut_index"}, 32'(a_idx), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        lut_a[0] = 24'h000503;
        lut_a[1] = 24'h00FF01;
        for (int i = 0; i < 12; i++) lut_b[i] = 24'h000000;
        lut_b[0] = 24'h001401;
        lut_b[1] = 24'hFFFFFF;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_csb", 32'(a_csb), 32'd1);
        check("rst_sclk", 32'(a_sclk), 32'd0);
        check("rst_sdo", 32'(a_sdo), 32'd0);
        check("rst_oe", 32'(a_oe), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_cfg_ok", 32'(a_ok), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_idx", 32'(a_idx), 32'd0);
        check("rst_eidx", 32'(a_eidx), 32'd0);
        check("rst_b_csb", 32'(b_csb), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: two-entry table
        clear_mon();
        pulse_start(1'b0);
        check("t1_busy_after_start", 32'(a_busy), 32'd1);
        wait_idle(1'b0, 2000, "t1");
        check_a_run("t1");

        // Test 3: start during SHIFT is ignored
        clear_mon();
        pulse_start(1'b0);
        n = 0;
        while (a_csb && n < 100) begin @(negedge clk); n++; end
        check("t3_csb_fall_timeout", 32'(a_csb), 32'd0);
        repeat (10) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_idle(1'b0, 2000, "t3");
        repeat (200) @(negedge clk);
        check_a_run("t3");
        check("t3_idle_after", 32'(a_busy), 32'd0);

        // Test 4: reset at bit 10 of frame 0
        clear_mon();
        pulse_start(1'b0);
        n = 0;
        while (a_bits < 10 && n < 200) begin @(negedge clk); n++; end
        check("t4_bit10_timeout", 32'(a_bits >= 10), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t4_csb", 32'(a_csb), 32'd1);
        check("t4_sclk", 32'(a_sclk), 32'd0);
        check("t4_busy", 32'(a_busy), 32'd0);
        check("t4_oe", 32'(a_oe), 32'd0);
        check("t4_idx", 32'(a_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_no_done", 32'(a_dones), 32'd0);
        check("t4_stays_idle", 32'(a_busy), 32'd0);
        clear_mon();
        pulse_start(1'b0);
        wait_idle(1'b0, 2000, "t4r");
        check_a_run("t4r");

        // Tests 2 and 6: end marker at entry 1, 1000-cycle startup
        clear_mon();
        pulse_start(1'b1);
        n = 0;
        while (b_csb && n < 5000) begin @(negedge clk); n++; end
        check("t6_startup_delay_1001_1002", 32'(n >= 1001 && n <= 1002), 32'd1);
        check("t6_no_sclk_before_csb", 32'(b_pre_edges), 32'd0);
        wait_idle(1'b1, 5000, "t2");
        check("t2_nframes", 32'(b_frames.size()), 32'(1 + VERIFY));
        if (b_frames.size() > 0) begin
            check("t2_frame0", 32'(b_frames[0]), 32'h001401);
            check("t2_csb_low0", 32'(b_lens[0]), 32'd96);
        end
        check("t2_dones", 32'(b_dones), 32'd1);
        check("t2_lut_index", 32'(b_idx), 32'd1);
        check("t2_cfg_ok", 32'(b_ok), 32'd1);
        check("t2_err", 32'(b_err), 32'd0);

`ifdef ADC_CFG_VERIFY_EN
        // Test 5: readback verify, index 3 reads back 0x00 instead of 0x01
        for (int i = 0; i < 12; i++) lut_b[i] = {16'(16'h0010 + i), 8'(8'h10 + i)};
        lut_b[3] = 24'h001301;
        lut_b[5] = 24'h00FF15;
        clear_mon();
        pulse_start(1'b1);
        wait_idle(1'b1, 20000, "t5");
        begin
            int nw = 0;
            foreach (b_frames[i]) if (!b_frames[i][23]) nw++;
            check("t5_writes", 32'(nw), 32'd12);
        end
        check("t5_nframes", 32'(b_frames.size()), 32'd23);
        if (b_frames.size() > 1) begin
            check("t5_frame0", 32'(b_frames[0]), 32'h001010);
            check("t5_frame1_read", 32'(b_frames[1]), 32'h801000);
        end
        check("t5_err", 32'(b_err), 32'd1);
        check("t5_err_index", 32'(b_eidx), 32'd3);
        check("t5_cfg_ok", 32'(b_ok), 32'd0);
        check("t5_dones", 32'(b_dones), 32'd1);
        check("t5_lut_index", 32'(b_idx), 32'd11);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
